conv2d_4_stream_scheduler: RTL
==============================

# conv2d_4_stream_scheduler

Sequencer for the 16-channel conv2d_4 filter datapath. It issues one shared read strobe to all input channel FIFOs only when every FIFO holds data and the downstream stage can accept. It tracks the pixel position inside the zero-padded input frame. It marks which read cycles produce a complete 3x3 window and delays that mark to line up with the adder output. It reports frame completion to the layer-level controller.

## Interface
Parameters:
- CHANNELS, 16, number of input channel FIFOs (one per conv2D lane)
- WIDTH, 56, output feature-map width; padded input row length is WIDTH+2
- HEIGHT, 56, output feature-map height; padded input frame has HEIGHT+2 rows
- PIPE_LAT, 4, cycles from a window-completing read to adder output valid (>=1)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE
- fifo_empty  in  CHANNELS  per-channel FIFO empty flags
- out_ready  in  1  downstream can accept a result this cycle
- rdreq  out  1  shared read strobe to all channel FIFOs and conv2D lanes
- window_valid  out  1  current rdreq completes a valid 3x3 window
- out_valid  out  1  window_valid delayed by PIPE_LAT cycles; qualifies data_out
- col  out  8  current padded column, 0..WIDTH+1
- row  out  8  current padded row, 0..HEIGHT+1
- busy  out  1  high in RUN and DRAIN
- frame_done  out  1  one-cycle pulse after the last result is emitted
- out_count  out  16  number of out_valid cycles since start

## Operation
- FSM states and transitions:
  - IDLE: start moves to RUN. The same edge clears col, row, out_count and the drain counter.
  - RUN: the last read (row==HEIGHT+1, col==WIDTH+1 with rdreq) moves to DRAIN.
  - DRAIN: waits PIPE_LAT cycles, then moves to DONE.
  - DONE: lasts one cycle, then returns to IDLE.
- rdreq = (state==RUN) & ~|fifo_empty & out_ready. It is combinational from registered state and the inputs.
- Position counters on each rdreq:
  - col increments.
  - At col==WIDTH+1, col wraps to 0 and row increments.
  - No change without rdreq.
- window_valid = rdreq & (row>=2) & (col>=2). This gives WIDTH*HEIGHT valid windows per frame.
- Delay line: a PIPE_LAT-deep shift register fed by window_valid. It shifts every cycle in every state. out_valid is its tail.
- out_count increments on each out_valid and holds its value after frame_done until the next start.
- frame_done is high exactly while in DONE.
- start in RUN, DRAIN or DONE is ignored.
- A single empty FIFO blocks all channels, so no lane is ever read alone.

## Timing
- Reset values: state=IDLE; rdreq, window_valid, out_valid, busy, frame_done = 0; col, row, out_count = 0; delay line cleared.
- start sampled at edge N: busy=1 from N+1; the earliest rdreq is in cycle N+1.
- Reads per frame: (WIDTH+2)*(HEIGHT+2), one per cycle at full throughput.
- out_valid follows the matching window_valid by exactly PIPE_LAT cycles.
- Last read at edge L: DRAIN from L+1 to L+PIPE_LAT, DONE in cycle L+PIPE_LAT+1, IDLE after that.
- out_ready low or any FIFO empty: rdreq drops in the same cycle and the counters hold. Already-issued windows still drain through the delay line.
- rst asserted mid-frame: all outputs return to reset values immediately, independent of clk. The partial frame is abandoned.
- Reset released with start high on the first edge: start is accepted.

## Test plan
- WIDTH=4, HEIGHT=4, PIPE_LAT=3, all FIFOs non-empty, out_ready=1, start pulse -> expected response:
  - 36 consecutive rdreq cycles.
  - window_valid on reads 15,16,17,18, 21..24, 27..30, 33..36 (16 total).
  - frame_done 4 cycles after the last read; out_count=16.
- Same setup, fifo_empty[9] held high for 5 cycles mid-row at col=3 -> expected response:
  - rdreq low for exactly those 5 cycles; col stays 3.
  - Total reads are still 36 and out_count=16.
- out_ready toggled 1/0 every cycle through the frame -> expected response:
  - rdreq only on high cycles; 72 RUN cycles.
  - Order of window_valid relative to reads unchanged.
- start pulsed again during RUN at read 10 -> expected response: ignored; frame completes normally with out_count=16.
- rst asserted at read 20 for one cycle, then start -> expected response:
  - Outputs zero during reset; no frame_done for the aborted frame.
  - The new frame yields 36 reads and out_count=16.
- Defaults (56x56, PIPE_LAT=4) -> expected response: 3364 reads, out_count=3136, single frame_done pulse.

Source files
------------

// File: rtl/conv2d_4_stream_scheduler.sv
// Read sequencer for the 16-lane conv2d_4 filter: issues a shared FIFO read strobe and walks the padded frame.
// Latency: rdreq is combinational in RUN; out_valid trails window_valid by PIPE_LAT cycles.
// Backpressure: any empty channel FIFO or out_ready low stalls rdreq and holds position; issued windows still drain.
module conv2d_4_stream_scheduler #(
    parameter int CHANNELS = 16,
    parameter int WIDTH    = 56,
    parameter int HEIGHT   = 56,
    parameter int PIPE_LAT = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [CHANNELS-1:0] fifo_empty_i,
    input  logic                out_ready_i,
    output logic                rdreq_o,
    output logic                window_valid_o,
    output logic                out_valid_o,
    output logic [7:0]          col_o,
    output logic [7:0]          row_o,
    output logic                busy_o,
    output logic                frame_done_o,
    output logic [15:0]         out_count_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] COL_LAST = 8'(WIDTH + 1);
    localparam logic [7:0] ROW_LAST = 8'(HEIGHT + 1);
    localparam int         DW       = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(PIPE_LAT - 1);

    state_t               state_q;
    logic                 busy_q;
    logic                 done_q;
    logic [DW-1:0]        drain_q;
    logic [7:0]           col_q, col_d;
    logic [7:0]           row_q, row_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [PIPE_LAT-1:0]  dly_q, dly_d;

    logic                 rd;
    logic                 win;
    logic                 last_rd;
    logic                 col_wrap;
    logic                 frame_start;

    // Read strobe and window qualification, all lanes gated together
    always_comb begin
        rd          = (state_q == S_RUN) & ~(|fifo_empty_i) & out_ready_i;
        col_wrap    = (col_q == COL_LAST);
        win         = rd & (row_q >= 8'd2) & (col_q >= 8'd2);
        last_rd     = rd & col_wrap & (row_q == ROW_LAST);
        frame_start = (state_q == S_IDLE) & start_i;
    end

    // Frame sequencing with registered busy and frame_done
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            drain_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        drain_q <= '0;
                    end
                end
                S_RUN: begin
                    if (last_rd) begin
                        state_q <= S_DRAIN;
                        drain_q <= '0;
                    end
                end
                S_DRAIN: begin
                    // Hold until the final window has left the delay line
                    if (drain_q == DRAIN_LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + DW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Padded-frame position: advance on each read, wrap row at end of frame
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (frame_start) begin
            col_d = '0;
            row_d = '0;
        end else if (rd) begin
            if (col_wrap) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? 8'd0 : row_q + 8'd1;
            end else begin
                col_d = col_q + 8'd1;
            end
        end
    end

    // Position registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Window mark delay line, shifts every cycle regardless of state
    generate
        if (PIPE_LAT == 1) begin : g_dly1
            always_comb dly_d = win;
        end else begin : g_dlyn
            always_comb dly_d = {dly_q[PIPE_LAT-2:0], win};
        end
    endgenerate

    // Delay line register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dly_q <= '0;
        end else begin
            dly_q <= dly_d;
        end
    end

    // Result count: cleared on frame start, held after frame_done
    always_comb begin
        cnt_d = cnt_q;
        if (frame_start) begin
            cnt_d = '0;
        end else if (dly_q[PIPE_LAT-1]) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Result count register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign rdreq_o        = rd;
    assign window_valid_o = win;
    assign out_valid_o    = dly_q[PIPE_LAT-1];
    assign col_o          = col_q;
    assign row_o          = row_q;
    assign busy_o         = busy_q;
    assign frame_done_o   = done_q;
    assign out_count_o    = cnt_q;

endmodule
